mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage of the 5-stage in-order MIPS pipeline. It sits between the execute stage and the write-back stage and receives the execute-stage bus, which carries the ALU/HI/LO result and the load-type decode. It takes the synchronous data-SRAM read data and performs byte/half extraction, sign/zero extension and LWL/LWR alignment. It produces a per-byte register-file write strobe and result for write-back, plus a forwarding bus back to decode.

Parameters:
ES_TO_MS_BUS_WD, 78, width of execute-to-memory bus
MS_TO_WS_BUS_WD, 73, width of memory-to-writeback bus
MS_FWD_BLK_BUS_WD, 42, width of forward/block bus to decode

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ws_allowin  in  1  write-back stage can accept
ms_allowin  out  1  this stage can accept
es_to_ms_valid  in  1  execute stage presents an instruction
es_to_ms_bus  in  78  {lb[77],lbu[76],lh[75],lhu[74],lw[73],lwl[72],lwr[71],res_from_mem[70],gr_we[69],dest[68:64],exe_result[63:32],pc[31:0]}
ms_to_ws_valid  out  1  instruction valid toward write-back
ms_to_ws_bus  out  73  {rf_wstrb[72:69],dest[68:64],final_result[63:32],pc[31:0]}
data_sram_rdata  in  32  data SRAM read data, valid the cycle after the address was issued in execute
ms_fwd_blk_bus  out  42  {fwd_valid[41:38],rf_dest[37:33],rf_data[32:1],blk_valid[0]}

Behaviour:
- Reset is synchronous and active-high on clk. It clears ms_valid and rdata_buf_valid. After reset: ms_allowin=1, ms_to_ws_valid=0, fwd_valid=0, blk_valid=0.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
  - When ms_allowin=1, ms_valid <= es_to_ms_valid.
  - The bus register is loaded only when es_to_ms_valid && ms_allowin. Its contents before the first load are don't-care; every consumer is gated by ms_valid.
- Read-data capture:
  - The SRAM output is valid only in the first cycle an instruction resides here, because execute may change the address afterwards.
  - On a cycle with ms_valid && !rdata_buf_valid && !ws_allowin: rdata_buf <= data_sram_rdata and rdata_buf_valid <= 1.
  - rdata_buf_valid clears on ms_valid && ws_allowin (instruction leaves) and on reset. Clear takes priority over set.
  - Effective rdata = rdata_buf_valid ? rdata_buf : data_sram_rdata.
  - A stall of any length must present identical output every cycle.
- Extraction: a = exe_result[1:0], r = effective rdata.
  - lb/lbu: byte r[8a+7:8a], sign-/zero-extended; strobe 1111.
  - lh/lhu: half selected by a[1] (r[15:0] or r[31:16]), extended; strobe 1111. a[0] is ignored (no alignment exception here).
  - lw: r; strobe 1111. a is ignored.
  - lwl: data = r << (8*(3-a)); strobe a=0:1000, 1:1100, 2:1110, 3:1111.
  - lwr: data = r >> (8*a); strobe a=0:1111, 1:0111, 2:0011, 3:0001.
  - Non-load with gr_we=1: final_result = exe_result; strobe 1111.
  - gr_we=0: strobe 0000; final_result = exe_result.
  - rf_wstrb is forced to 0000 when ms_valid=0.
- Forwarding:
  - fwd_valid = rf_wstrb when ms_valid, else 0000.
  - rf_dest = dest; rf_data = final_result.
  - blk_valid = 0 always: load data is resolved in this stage.
- Simultaneous events:
  - Accept and drain in the same cycle: the new instruction replaces the old and rdata_buf_valid clears.
  - Reset mid-stall discards the held instruction and the buffer.

Test Plan:
- lw at 0x1000 with rdata 0x8899AABB, ws_allowin=1 -> next-cycle bus {1111, dest, 0x8899AABB, pc}; fwd_valid=1111, blk_valid=0.
- lb a=3, rdata 0x80112233 -> 0xFFFFFF80. lbu same -> 0x00000080. lh a=2 -> 0xFFFF8011. lhu -> 0x00008011.
- lwl a=1, rdata 0xAABBCCDD -> data 0xCCDD0000, strobe 1100. lwr a=1 -> 0x00AABBCC, strobe 0111. lwr a=3 -> 0x000000AA, strobe 0001.
- lb a=0, first-cycle rdata 0x12345678; hold ws_allowin=0 for 3 cycles while rdata changes to 0xDEADBEEF -> result stays 0x00000078 every cycle. Release -> one handoff, then rdata_buf_valid=0.
- Back-to-back ALU op (gr_we=1, result 0x5) then sw (gr_we=0) -> strobes 1111 then 0000; fwd_valid follows.
- reset asserted during a stall -> next cycle ms_to_ws_valid=0, ms_allowin=1, fwd_valid=0000.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline: holds one instruction from
// execute, extracts/extends load data from the data SRAM, and drives the
// write-back bus and the forwarding bus back to decode.
module mem_stage #(
   parameter int unsigned ES_TO_MS_BUS_WD   = 78,
   parameter int unsigned MS_TO_WS_BUS_WD   = 73,
   parameter int unsigned MS_FWD_BLK_BUS_WD = 42
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ws_allowin,
   output logic                         ms_allowin,
   input  logic                         es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
   output logic                         ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
   input  logic [31:0]                  data_sram_rdata,
   output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned DEST_W  = 5;
   localparam int unsigned STRB_W  = 4;

   logic                       ms_valid;
   logic                       ms_ready_go;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
   logic [DATA_W-1:0]          rdata_buf;
   logic                       rdata_buf_valid;

   // decoded fields of the held execute-stage payload
   logic                       ms_lb, ms_lbu, ms_lh, ms_lhu, ms_lw, ms_lwl, ms_lwr;
   logic                       ms_res_from_mem;
   logic                       ms_gr_we;
   logic [DEST_W-1:0]          ms_dest;
   logic [DATA_W-1:0]          ms_exe_result;
   logic [DATA_W-1:0]          ms_pc;

   logic [DATA_W-1:0]          ms_rdata;
   logic [1:0]                 addr_lo;
   logic [7:0]                 byte_sel;
   logic [15:0]                half_sel;
   logic [STRB_W-1:0]          wstrb_raw;
   logic [STRB_W-1:0]          rf_wstrb;
   logic [DATA_W-1:0]          final_result;

   assign {ms_lb, ms_lbu, ms_lh, ms_lhu, ms_lw, ms_lwl, ms_lwr,
           ms_res_from_mem, ms_gr_we, ms_dest, ms_exe_result, ms_pc} = es_to_ms_bus_r;

   // handshake: the stage never stalls on its own
   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;

   // stage occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
      end
   end

   // payload register, loaded only on an accepted instruction
   always_ff @(posedge clk) begin
      if (es_to_ms_valid && ms_allowin) begin
         es_to_ms_bus_r <= es_to_ms_bus;
      end
   end

   // SRAM data is only valid in the first resident cycle; keep it across stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_buf_valid <= 1'b0;
      end else if (ms_valid && ws_allowin) begin
         rdata_buf_valid <= 1'b0;
      end else if (ms_valid && !rdata_buf_valid && !ws_allowin) begin
         rdata_buf_valid <= 1'b1;
      end
   end

   // buffered read data payload
   always_ff @(posedge clk) begin
      if (ms_valid && !rdata_buf_valid && !ws_allowin) begin
         rdata_buf <= data_sram_rdata;
      end
   end

   assign ms_rdata = rdata_buf_valid ? rdata_buf : data_sram_rdata;
   assign addr_lo  = ms_exe_result[1:0];

   // byte and halfword lanes addressed by the low address bits
   always_comb begin
      byte_sel = ms_rdata[7:0];
      case (addr_lo)
         2'd0: byte_sel = ms_rdata[7:0];
         2'd1: byte_sel = ms_rdata[15:8];
         2'd2: byte_sel = ms_rdata[23:16];
         2'd3: byte_sel = ms_rdata[31:24];
         default: byte_sel = ms_rdata[7:0];
      endcase
      half_sel = addr_lo[1] ? ms_rdata[31:16] : ms_rdata[15:0];
   end

   // result and write-strobe selection per instruction type
   always_comb begin
      final_result = ms_exe_result;
      wstrb_raw    = 4'b0000;
      if (ms_gr_we) begin
         wstrb_raw = 4'b1111;
         if (ms_res_from_mem) begin
            if (ms_lb) begin
               final_result = {{24{byte_sel[7]}}, byte_sel};
            end else if (ms_lbu) begin
               final_result = {24'd0, byte_sel};
            end else if (ms_lh) begin
               final_result = {{16{half_sel[15]}}, half_sel};
            end else if (ms_lhu) begin
               final_result = {16'd0, half_sel};
            end else if (ms_lwl) begin
               case (addr_lo)
                  2'd0: begin final_result = {ms_rdata[7:0], 24'd0};  wstrb_raw = 4'b1000; end
                  2'd1: begin final_result = {ms_rdata[15:0], 16'd0}; wstrb_raw = 4'b1100; end
                  2'd2: begin final_result = {ms_rdata[23:0], 8'd0};  wstrb_raw = 4'b1110; end
                  default: begin final_result = ms_rdata;             wstrb_raw = 4'b1111; end
               endcase
            end else if (ms_lwr) begin
               case (addr_lo)
                  2'd0: begin final_result = ms_rdata;                 wstrb_raw = 4'b1111; end
                  2'd1: begin final_result = {8'd0, ms_rdata[31:8]};   wstrb_raw = 4'b0111; end
                  2'd2: begin final_result = {16'd0, ms_rdata[31:16]}; wstrb_raw = 4'b0011; end
                  default: begin final_result = {24'd0, ms_rdata[31:24]}; wstrb_raw = 4'b0001; end
               endcase
            end else begin
               // lw, and any load flag combination without a narrower type
               final_result = ms_rdata;
            end
         end
      end
   end

   assign rf_wstrb = ms_valid ? wstrb_raw : 4'b0000;

   // outgoing buses; load data resolves here so decode never needs to block
   assign ms_to_ws_bus   = {rf_wstrb, ms_dest, final_result, ms_pc};
   assign ms_fwd_blk_bus = {rf_wstrb, ms_dest, final_result, 1'b0};

   // ms_lw is implied by the default branch; keep it referenced
   logic unused_ok;
   assign unused_ok = ms_lw;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// stall/reset sequences and randomized instructions against a reference model.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [77:0] es_to_ms_bus;
   logic        ms_to_ws_valid;
   logic [72:0] ms_to_ws_bus;
   logic [31:0] data_sram_rdata;
   logic [41:0] ms_fwd_blk_bus;

   int n_pass  = 0;
   int n_total = 0;

   mem_stage dut (
      .clk            (clk),
      .reset          (reset),
      .ws_allowin     (ws_allowin),
      .ms_allowin     (ms_allowin),
      .es_to_ms_valid (es_to_ms_valid),
      .es_to_ms_bus   (es_to_ms_bus),
      .ms_to_ws_valid (ms_to_ws_valid),
      .ms_to_ws_bus   (ms_to_ws_bus),
      .data_sram_rdata(data_sram_rdata),
      .ms_fwd_blk_bus (ms_fwd_blk_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // load-type one-hot order {lb,lbu,lh,lhu,lw,lwl,lwr}
   localparam logic [6:0] T_NONE = 7'b0000000;
   localparam logic [6:0] T_LB   = 7'b1000000;
   localparam logic [6:0] T_LBU  = 7'b0100000;
   localparam logic [6:0] T_LH   = 7'b0010000;
   localparam logic [6:0] T_LHU  = 7'b0001000;
   localparam logic [6:0] T_LW   = 7'b0000100;
   localparam logic [6:0] T_LWL  = 7'b0000010;
   localparam logic [6:0] T_LWR  = 7'b0000001;

   typedef struct {
      logic [6:0]  ld;
      logic        gr_we;
      logic [31:0] exe;
      logic [31:0] rdata;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   function automatic logic [77:0] mk_bus(input logic [6:0] ld, input logic gr_we,
                                          input logic [4:0] dest, input logic [31:0] exe,
                                          input logic [31:0] pc);
      return {ld, |ld, gr_we, dest, exe, pc};
   endfunction

   // reference model: returns {wstrb, result} from the instruction semantics
   function automatic logic [35:0] model(input logic [6:0] ld, input logic gr_we,
                                         input logic [31:0] exe, input logic [31:0] r);
      int a;
      logic [31:0] sh;
      logic [31:0] res;
      logic [3:0]  st;
      a  = int'(exe[1:0]);
      sh = r >> (8 * a);
      st = 4'hF;
      res = exe;
      if (!gr_we) return {4'h0, exe};
      case (ld)
         T_LB:  res = {{24{sh[7]}}, sh[7:0]};
         T_LBU: res = {24'd0, sh[7:0]};
         T_LH:  begin sh = r >> (16 * (a / 2)); res = {{16{sh[15]}}, sh[15:0]}; end
         T_LHU: begin sh = r >> (16 * (a / 2)); res = {16'd0, sh[15:0]}; end
         T_LW:  res = r;
         T_LWL: begin res = r << (8 * (3 - a)); st = 4'(4'hF << (3 - a)); end
         T_LWR: begin res = r >> (8 * a);       st = 4'(4'hF >> a); end
         default: res = exe;
      endcase
      return {st, res};
   endfunction

   // drive an instruction into the stage; returns after the accepting edge (+1)
   task automatic issue(input logic [6:0] ld, input logic gr_we, input logic [4:0] dest,
                        input logic [31:0] exe, input logic [31:0] pc, input logic [31:0] rd);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(ld, gr_we, dest, exe, pc);
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      es_to_ms_bus    = 78'(0);
      data_sram_rdata = rd;
   endtask

   task automatic chk_out(input string name, input logic [4:0] dest, input logic [31:0] pc,
                          input logic [3:0] st, input logic [31:0] res);
      chk({name, ".valid"}, 73'(ms_to_ws_valid), 73'(1));
      chk({name, ".ws_bus"}, ms_to_ws_bus, {st, dest, res, pc});
      chk({name, ".fwd"}, 73'(ms_fwd_blk_bus), 73'({st, dest, res, 1'b0}));
   endtask

   initial begin
      logic [35:0] m;
      logic [4:0]  dest;
      logic [31:0] pc, exe, rd;
      logic [6:0]  ld;
      logic        we;
      int          handoffs;
      int          k;
      logic [6:0]  types [8];

      types = '{T_NONE, T_LB, T_LBU, T_LH, T_LHU, T_LW, T_LWL, T_LWR};

      vecs[0]  = '{T_LW,   1'b1, 32'h0000_1000, 32'h8899_AABB, 4'b1111, 32'h8899_AABB};
      vecs[1]  = '{T_LB,   1'b1, 32'h0000_2003, 32'h8011_2233, 4'b1111, 32'hFFFF_FF80};
      vecs[2]  = '{T_LBU,  1'b1, 32'h0000_2003, 32'h8011_2233, 4'b1111, 32'h0000_0080};
      vecs[3]  = '{T_LH,   1'b1, 32'h0000_2002, 32'h8011_2233, 4'b1111, 32'hFFFF_8011};
      vecs[4]  = '{T_LHU,  1'b1, 32'h0000_2002, 32'h8011_2233, 4'b1111, 32'h0000_8011};
      vecs[5]  = '{T_LWL,  1'b1, 32'h0000_3001, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_0000};
      vecs[6]  = '{T_LWR,  1'b1, 32'h0000_3001, 32'hAABB_CCDD, 4'b0111, 32'h00AA_BBCC};
      vecs[7]  = '{T_LWR,  1'b1, 32'h0000_3003, 32'hAABB_CCDD, 4'b0001, 32'h0000_00AA};
      vecs[8]  = '{T_NONE, 1'b1, 32'h0000_0005, 32'h1234_5678, 4'b1111, 32'h0000_0005};
      vecs[9]  = '{T_NONE, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'b0000, 32'h0000_2000};
      vecs[10] = '{T_LH,   1'b1, 32'h0000_2001, 32'h8011_2233, 4'b1111, 32'h0000_2233};
      vecs[11] = '{T_LWL,  1'b1, 32'h0000_3000, 32'hAABB_CCDD, 4'b1000, 32'hDD00_0000};
      vecs[12] = '{T_LWR,  1'b1, 32'h0000_3000, 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD};

      reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
      es_to_ms_bus = 78'(0); data_sram_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst.allowin", 73'(ms_allowin), 73'(1));
      chk("rst.valid",   73'(ms_to_ws_valid), 73'(0));
      chk("rst.fwd_valid", 73'(ms_fwd_blk_bus[41:38]), 73'(0));
      chk("rst.blk",     73'(ms_fwd_blk_bus[0]), 73'(0));

      // directed table, back-to-back with write-back always ready
      for (int i = 0; i < 13; i++) begin
         dest = 5'(i + 1);
         pc   = 32'hBFC0_0000 + 32'(4 * i);
         issue(vecs[i].ld, vecs[i].gr_we, dest, vecs[i].exe, pc, vecs[i].rdata);
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), dest, pc, vecs[i].exp_wstrb, vecs[i].exp_res);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("drain.valid", 73'(ms_to_ws_valid), 73'(0));
      chk("drain.fwd_valid", 73'(ms_fwd_blk_bus[41:38]), 73'(0));

      // stall: first-cycle data must be held while the SRAM output changes
      issue(T_LB, 1'b1, 5'd7, 32'h0000_4000, 32'h0000_4444, 32'h1234_5678);
      ws_allowin = 1'b0;
      @(negedge clk);
      chk_out("stall0", 5'd7, 32'h0000_4444, 4'b1111, 32'h0000_0078);
      chk("stall0.allowin", 73'(ms_allowin), 73'(0));
      for (int c = 1; c < 3; c++) begin
         @(posedge clk); #1 data_sram_rdata = 32'hDEAD_BEEF;
         @(negedge clk);
         chk_out($sformatf("stall%0d", c), 5'd7, 32'h0000_4444, 4'b1111, 32'h0000_0078);
      end
      @(posedge clk); #1 ws_allowin = 1'b1;
      @(negedge clk);
      chk_out("release", 5'd7, 32'h0000_4444, 4'b1111, 32'h0000_0078);
      handoffs = 0;
      for (int c = 0; c < 3; c++) begin
         if (ms_to_ws_valid && ws_allowin) handoffs++;
         @(posedge clk); #1;
         @(negedge clk);
      end
      chk("handoffs", 73'(handoffs), 73'(1));
      // a fresh load must see live SRAM data, not the old buffer
      issue(T_LB, 1'b1, 5'd8, 32'h0000_4000, 32'h0000_4448, 32'h0000_0011);
      ws_allowin = 1'b0;
      @(negedge clk);
      chk_out("post_stall", 5'd8, 32'h0000_4448, 4'b1111, 32'h0000_0011);
      @(posedge clk); #1 data_sram_rdata = 32'h0000_0022;

      // reset in the middle of that stall
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_stall.valid", 73'(ms_to_ws_valid), 73'(0));
      chk("rst_stall.allowin", 73'(ms_allowin), 73'(1));
      chk("rst_stall.fwd_valid", 73'(ms_fwd_blk_bus[41:38]), 73'(0));
      issue(T_LBU, 1'b1, 5'd9, 32'h0000_5000, 32'h0000_5000, 32'h0000_0033);
      @(negedge clk);
      chk_out("rst_stall.fresh", 5'd9, 32'h0000_5000, 4'b1111, 32'h0000_0033);
      ws_allowin = 1'b1;

      // randomized instructions with random stalls against the model
      for (int n = 0; n < 150; n++) begin
         ld   = types[$urandom_range(0, 7)];
         we   = ($urandom_range(0, 7) != 0);
         dest = 5'($urandom);
         pc   = $urandom;
         exe  = $urandom;
         rd   = $urandom;
         k    = $urandom_range(0, 3);
         m    = model(ld, we, exe, rd);
         ws_allowin = 1'b1;
         issue(ld, we, dest, exe, pc, rd);
         for (int j = 0; j < k; j++) begin
            ws_allowin = 1'b0;
            @(negedge clk);
            chk_out($sformatf("rnd%0d.s%0d", n, j), dest, pc, m[35:32], m[31:0]);
            @(posedge clk); #1 data_sram_rdata = $urandom;
         end
         ws_allowin = 1'b1;
         @(negedge clk);
         chk_out($sformatf("rnd%0d", n), dest, pc, m[35:32], m[31:0]);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
